// File: rtl/hazard_flush_ctrl.sv
// rtl/hazard_flush_ctrl.sv - decode-stage RAW hazard, forwarding select and branch-flush control
// Optional feature macro: FORWARDING_EN (undefined: no bypass, stall until producer reaches WB)
module hazard_flush_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             de_valid_i,
  input  logic [4:0]       de_rs1_i,
  input  logic [4:0]       de_rs2_i,
  input  logic             de_uses_rs1_i,
  input  logic             de_uses_rs2_i,
  input  logic [4:0]       de_rd_i,
  input  logic             de_reg_write_i,
  input  logic             de_mem_read_i,
  input  logic             ex_branch_taken_i,
  output logic             stall_o,
  output logic             bubble_o,
  output logic             flush_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic {RUN, FLUSHING} state_e;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_e           state_q;
  logic [2:0]       flush_left_q;
  logic             ex_valid_q, ex_load_q, mem_valid_q;
  logic [4:0]       ex_rd_q, mem_rd_q;
  logic [1:0]       fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic m_ex1, m_ex2, m_mem1, m_mem2;
  logic hazard, flush_now, stall, bubble;
  logic ex_valid_d;

  function automatic logic [1:0] fwd_sel(input logic m_ex, input logic m_mem);
    if (m_ex)       return 2'b01;
    else if (m_mem) return 2'b10;
    else            return 2'b00;
  endfunction

  always_comb begin
    m_ex1  = ex_valid_q  & de_uses_rs1_i & (de_rs1_i == ex_rd_q)  & (de_rs1_i != 5'd0);
    m_ex2  = ex_valid_q  & de_uses_rs2_i & (de_rs2_i == ex_rd_q)  & (de_rs2_i != 5'd0);
    m_mem1 = mem_valid_q & de_uses_rs1_i & (de_rs1_i == mem_rd_q) & (de_rs1_i != 5'd0);
    m_mem2 = mem_valid_q & de_uses_rs2_i & (de_rs2_i == mem_rd_q) & (de_rs2_i != 5'd0);
`ifdef FORWARDING_EN
    // Only a load in EX cannot be bypassed; everything else forwards.
    hazard  = ex_load_q & (m_ex1 | m_ex2);
    fwd_a_d = fwd_sel(m_ex1, m_mem1);
    fwd_b_d = fwd_sel(m_ex2, m_mem2);
`else
    hazard  = m_ex1 | m_ex2 | m_mem1 | m_mem2;
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
`endif
    flush_now  = rst_n_i & (ex_branch_taken_i | (state_q == FLUSHING));
    stall      = rst_n_i & hazard & ~flush_now;
    bubble     = flush_now | (rst_n_i & hazard);
    ex_valid_d = de_valid_i & de_reg_write_i & (de_rd_i != 5'd0) & ~bubble;
  end

`ifndef FORWARDING_EN
  logic unused_load;
  assign unused_load = ex_load_q;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= RUN;
      flush_left_q <= 3'd0;
      ex_valid_q   <= 1'b0;
      ex_rd_q      <= 5'd0;
      ex_load_q    <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_rd_q     <= 5'd0;
      fwd_a_q      <= 2'b00;
      fwd_b_q      <= 2'b00;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      mem_valid_q <= ex_valid_q;
      mem_rd_q    <= ex_rd_q;
      ex_valid_q  <= ex_valid_d;
      ex_rd_q     <= de_rd_i;
      ex_load_q   <= de_mem_read_i;
      fwd_a_q     <= bubble ? 2'b00 : fwd_a_d;
      fwd_b_q     <= bubble ? 2'b00 : fwd_b_d;

      // A taken branch always restarts the flush window, even mid-flush.
      if (ex_branch_taken_i) begin
        if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
        state_q      <= (FLUSH_CYCLES > 1) ? FLUSHING : RUN;
        flush_left_q <= FLUSH_RELOAD;
      end else if (state_q == FLUSHING) begin
        if (flush_left_q <= 3'd1) state_q <= RUN;
        flush_left_q <= flush_left_q - 3'd1;
      end

      if (stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_o     = stall;
  assign bubble_o    = bubble;
  assign flush_o     = flush_now;
  assign fwd_a_o     = fwd_a_q;
  assign fwd_b_o     = fwd_b_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
